// File: rtl/spi_flash_pkg.sv
// Shared opcodes, state encoding and timing constants for the SPI flash responder.
// SPI_RESP_FAST_READ_EN adds the DUMMY state used by FAST READ (0x0B).
package spi_flash_pkg;

    localparam logic [7:0] OPC_READ      = 8'h03;
    localparam logic [7:0] OPC_FAST_READ = 8'h0B;
    localparam int         DUMMY_CYCLES  = 8;
    localparam int         WIRE_ADDR_W   = 24;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
`ifdef SPI_RESP_FAST_READ_EN
        DUMMY,
`endif
        DATA,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchroniser for the SPI pins: level outputs for csb/mosi, one-clk rise/fall
// pulses for sck taken from the last two synchroniser stages.
module spi_edge_sync
    import spi_flash_pkg::*;
#(
    parameter int SYNC_FF = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic csb,
    input  logic sck,
    input  logic mosi,
    output logic csb_s,
    output logic mosi_s,
    output logic sck_rise,
    output logic sck_fall
);

    logic [SYNC_FF-1:0] csb_ff;
    logic [SYNC_FF-1:0] sck_ff;
    logic [SYNC_FF-1:0] mosi_ff;

    // csb resets to "selected" so a chip select that is already low when reset
    // releases never looks like a fresh falling edge; a transfer needs high-then-low.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csb_ff  <= '0;
            sck_ff  <= '0;
            mosi_ff <= '0;
        end else begin
            csb_ff  <= {csb_ff[SYNC_FF-2:0], csb};
            sck_ff  <= {sck_ff[SYNC_FF-2:0], sck};
            mosi_ff <= {mosi_ff[SYNC_FF-2:0], mosi};
        end
    end

    assign csb_s    = csb_ff[SYNC_FF-1];
    assign mosi_s   = mosi_ff[SYNC_FF-1];
    assign sck_rise =  sck_ff[SYNC_FF-2] & ~sck_ff[SYNC_FF-1];
    assign sck_fall = ~sck_ff[SYNC_FF-2] &  sck_ff[SYNC_FF-1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI flash target serving READ (0x03) from a synchronous byte memory, oversampling SCK.
// Define SPI_RESP_FAST_READ_EN to also accept FAST READ (0x0B) with 8 dummy clocks.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int SYNC_FF = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_csb,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_oe,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    logic csb_s;
    logic mosi_s;
    logic sck_rise;
    logic sck_fall;

    spi_edge_sync #(
        .SYNC_FF (SYNC_FF)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .csb      (spi_csb),
        .sck      (spi_sck),
        .mosi     (spi_mosi),
        .csb_s    (csb_s),
        .mosi_s   (mosi_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    state_t            state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [2:0]        fall_cnt_q, fall_cnt_d;
    logic [22:0]       shreg_q, shreg_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        tx_q, tx_d;
    logic [7:0]        hold_q, hold_d;
    logic              ld_tx_q, ld_tx_d;
    logic              ld_hold_q, ld_hold_d;
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic              csb_prev_q;
`ifdef SPI_RESP_FAST_READ_EN
    logic              fast_q, fast_d;
`endif

    logic [WIRE_ADDR_W-1:0] addr_full;
    logic [ADDR_W-1:0]      addr_wire;
    logic [ADDR_W-1:0]      addr_inc;
    logic [7:0]             opcode;

    assign addr_full = {shreg_q, mosi_s};
    assign addr_wire = addr_full[ADDR_W-1:0];
    assign addr_inc  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign opcode    = {shreg_q[6:0], mosi_s};

    // NOTE: the TX/hold data registers are reset along with control; there are only
    // two of them and it keeps spi_miso deterministic after an aborted transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            fall_cnt_q <= '0;
            shreg_q    <= '0;
            addr_q     <= '0;
            tx_q       <= '0;
            hold_q     <= '0;
            ld_tx_q    <= 1'b0;
            ld_hold_q  <= 1'b0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            csb_prev_q <= 1'b0;
`ifdef SPI_RESP_FAST_READ_EN
            fast_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            fall_cnt_q <= fall_cnt_d;
            shreg_q    <= shreg_d;
            addr_q     <= addr_d;
            tx_q       <= tx_d;
            hold_q     <= hold_d;
            ld_tx_q    <= ld_tx_d;
            ld_hold_q  <= ld_hold_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            csb_prev_q <= csb_s;
`ifdef SPI_RESP_FAST_READ_EN
            fast_q     <= fast_d;
`endif
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        fall_cnt_d = fall_cnt_q;
        shreg_d    = shreg_q;
        addr_d     = addr_q;
        tx_d       = tx_q;
        hold_d     = hold_q;
        ld_tx_d    = 1'b0;
        ld_hold_d  = 1'b0;
        miso_d     = miso_q;
        oe_d       = oe_q;
        mem_rd     = 1'b0;
        mem_addr   = '0;
`ifdef SPI_RESP_FAST_READ_EN
        fast_d     = fast_q;
`endif

        // Memory data arrives one clk after the strobe that requested it.
        if (ld_tx_q) tx_d = mem_rdata;
        if (ld_hold_q) hold_d = mem_rdata;

        if (csb_s) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            fall_cnt_d = '0;
            miso_d     = 1'b0;
            oe_d       = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (csb_prev_q) begin
                        state_d    = CMD;
                        bit_cnt_d  = '0;
                        fall_cnt_d = '0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        shreg_d   = {shreg_q[21:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            if (opcode == OPC_READ) begin
                                state_d = ADDR;
`ifdef SPI_RESP_FAST_READ_EN
                                fast_d  = 1'b0;
                            end else if (opcode == OPC_FAST_READ) begin
                                state_d = ADDR;
                                fast_d  = 1'b1;
`endif
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        shreg_d   = {shreg_q[21:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'(WIRE_ADDR_W - 1)) begin
                            mem_rd     = 1'b1;
                            mem_addr   = addr_wire;
                            addr_d     = addr_wire;
                            ld_tx_d    = 1'b1;
                            bit_cnt_d  = '0;
                            fall_cnt_d = '0;
`ifdef SPI_RESP_FAST_READ_EN
                            state_d    = fast_q ? DUMMY : DATA;
`else
                            state_d    = DATA;
`endif
                        end
                    end
                end
`ifdef SPI_RESP_FAST_READ_EN
                DUMMY: begin
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'(DUMMY_CYCLES - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = DATA;
                        end
                    end
                end
`endif
                DATA: begin
                    // Falls shift out MSB first; the 8th fall swaps in the prefetched byte.
                    if (sck_fall) begin
                        miso_d     = tx_q[7];
                        oe_d       = 1'b1;
                        fall_cnt_d = fall_cnt_q + 3'd1;
                        tx_d       = (fall_cnt_q == 3'd7) ? hold_q : {tx_q[6:0], 1'b0};
                    end
                    if (sck_rise) begin
                        bit_cnt_d = {2'b00, 3'(bit_cnt_q[2:0] + 3'd1)};
                        if (bit_cnt_q[2:0] == 3'd3) begin
                            mem_rd    = 1'b1;
                            mem_addr  = addr_inc;
                            addr_d    = addr_inc;
                            ld_hold_d = 1'b1;
                        end
                    end
                end
                IGNORE: begin
                    oe_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign spi_miso = miso_q;
    assign spi_oe   = oe_q & ~csb_s;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized self-checking bench for spi_flash_responder; expected bytes come
// from the memory rule mem[a] = a[7:0] ^ 8'h5A applied to the wrapped address stream.
module tb_spi_flash_responder;
    import spi_flash_pkg::*;

    localparam int ADDR_W  = 24;
    localparam int SYNC_FF = 2;

    logic              clk;
    logic              reset;
    logic              spi_csb;
    logic              spi_sck;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_oe;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [ADDR_W-1:0] rd_q[$];
    int                oe_hi_clks = 0;

    spi_flash_responder #(
        .ADDR_W  (ADDR_W),
        .SYNC_FF (SYNC_FF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_csb   (spi_csb),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .spi_oe    (spi_oe),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial mem_rdata = 8'h00;
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem_addr[7:0] ^ 8'h5A;
    end

    always @(negedge clk) begin
        if (mem_rd) rd_q.push_back(mem_addr);
        if (spi_oe) oe_hi_clks++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model_byte(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One SCK period at clk/8: mosi set while low, miso/oe sampled at the initiator's rise.
    task automatic sck_bit(input logic b, output logic miso_s, output logic oe_s);
        spi_mosi = b;
        repeat (4) @(negedge clk);
        miso_s  = spi_miso;
        oe_s    = spi_oe;
        spi_sck = 1'b1;
        repeat (4) @(negedge clk);
        spi_sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        logic m, o;
        for (int i = 7; i >= 0; i--) sck_bit(v[i], m, o);
    endtask

    task automatic read_byte(output logic [7:0] v, output logic oe_all);
        logic m, o;
        v      = 8'h00;
        oe_all = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sck_bit(1'b0, m, o);
            v      = {v[6:0], m};
            oe_all = oe_all & o;
        end
    endtask

    task automatic cs_start();
        spi_csb = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (2) @(negedge clk);
        spi_csb = 1'b1;
        repeat (SYNC_FF + 4) @(negedge clk);
    endtask

    task automatic do_xfer(input string tag, input logic [7:0] opc, input logic [ADDR_W-1:0] a,
                           input int nbytes, input int ndummy, input bit expect_data);
        logic [7:0]        v;
        logic              oe_all;
        logic              m, o;
        logic [ADDR_W-1:0] ak;
        rd_q.delete();
        oe_hi_clks = 0;
        cs_start();
        send_byte(opc);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        check($sformatf("%s_oe_pre_data", tag), spi_oe, 1'b0);
        for (int i = 0; i < ndummy; i++) sck_bit(1'b0, m, o);
        for (int k = 0; k < nbytes; k++) begin
            read_byte(v, oe_all);
            if (expect_data) begin
                ak = a + ADDR_W'(k);
                check($sformatf("%s_byte%0d", tag, k), v, model_byte(ak));
                check($sformatf("%s_oe%0d", tag, k), oe_all, 1'b1);
            end
        end
        if (!expect_data) check($sformatf("%s_busy_ignore", tag), busy, 1'b1);
        cs_end();
        check($sformatf("%s_busy_idle", tag), busy, 1'b0);
        check($sformatf("%s_oe_idle", tag), spi_oe, 1'b0);
        if (expect_data) begin
            check($sformatf("%s_rd_count", tag), rd_q.size(), nbytes + 1);
            for (int k = 0; k < rd_q.size() && k <= nbytes; k++) begin
                ak = a + ADDR_W'(k);
                check($sformatf("%s_rd_addr%0d", tag, k), rd_q[k], ak);
            end
        end else begin
            check($sformatf("%s_rd_count", tag), rd_q.size(), 0);
            check($sformatf("%s_oe_clks", tag), oe_hi_clks, 0);
        end
    endtask

    initial begin
        logic [7:0]        v;
        logic              oe_all;
        logic              m, o;
        logic [ADDR_W-1:0] ra;
        logic [7:0]        ropc;
        int                rn;

        reset    = 1'b1;
        spi_csb  = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_oe", spi_oe, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (SYNC_FF + 3) @(negedge clk);

        do_xfer("read10", OPC_READ, 24'h000010, 4, 0, 1'b1);
        do_xfer("wrap", OPC_READ, 24'hFFFFFE, 4, 0, 1'b1);

        // Abort mid-byte, then a clean read must start from fresh data.
        cs_start();
        send_byte(OPC_READ);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        for (int i = 0; i < 3; i++) sck_bit(1'b0, m, o);
        check("abort_oe_before", spi_oe, 1'b1);
        spi_csb = 1'b1;
        repeat (SYNC_FF + 1) @(negedge clk);
        check("abort_oe_low", spi_oe, 1'b0);
        repeat (4) @(negedge clk);
        check("abort_busy", busy, 1'b0);
        do_xfer("after_abort", OPC_READ, 24'h000000, 2, 0, 1'b1);

        do_xfer("opc_ab", 8'hAB, 24'h000000, 0, 0, 1'b0);

`ifdef SPI_RESP_FAST_READ_EN
        do_xfer("fast", OPC_FAST_READ, 24'h000020, 2, DUMMY_CYCLES, 1'b1);
`else
        do_xfer("fast_off", OPC_FAST_READ, 24'h000020, 2, DUMMY_CYCLES, 1'b0);
`endif

        // Reset during DATA while the presented bit is a one (byte 1 = 0x1B, bit 4).
        cs_start();
        send_byte(OPC_READ);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h40);
        read_byte(v, oe_all);
        check("pre_reset_byte0", v, model_byte(24'h000040));
        for (int i = 0; i < 3; i++) sck_bit(1'b0, m, o);
        repeat (3) @(negedge clk);
        check("pre_reset_miso", spi_miso, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_miso", spi_miso, 1'b0);
        check("mid_rst_oe", spi_oe, 1'b0);
        check("mid_rst_mem_rd", mem_rd, 1'b0);
        check("mid_rst_mem_addr", mem_addr, '0);
        check("mid_rst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        spi_csb = 1'b1;
        reset   = 1'b0;
        repeat (SYNC_FF + 3) @(negedge clk);
        do_xfer("after_reset", OPC_READ, 24'h000040, 2, 0, 1'b1);

        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 3) == 0) ra = 24'hFFFFFF - ADDR_W'($urandom_range(0, 3));
            else ra = ADDR_W'($urandom);
            rn = $urandom_range(1, 4);
            do_xfer($sformatf("rnd%0d", t), OPC_READ, ra, rn, 0, 1'b1);
        end

        for (int t = 0; t < 3; t++) begin
            ropc = 8'($urandom);
            if (ropc == OPC_READ || ropc == OPC_FAST_READ) ropc = ropc ^ 8'h80;
            do_xfer($sformatf("rnd_opc%0d", t), ropc, ADDR_W'($urandom), 2, 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
